// File: rtl/tanque_sensor_nivel.sv
// tanque_sensor_nivel: tank volume/level plant model with fertiliser-dosing FSM
// Volume integrates on a prescaled tick; Nv* are compares of the registered volume.
module tanque_sensor_nivel #(
    parameter int VOL_W      = 8,
    parameter int CAP        = 200,
    parameter int TH0        = 20,
    parameter int TH1        = 100,
    parameter int TH2        = 180,
    parameter int FILL_STEP  = 4,
    parameter int DRAIN_STEP = 2,
    parameter int CLEAN_STEP = 8,
    parameter int TICK_DIV   = 4,
    parameter int MIX_TICKS  = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic Ve,
    input  logic Mist,
    input  logic Limp,
    input  logic Asp,
    output logic Nv0,
    output logic Nv1,
    output logic Nv2,
    output logic Adub,
    output logic Ovf
);
    localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam int MW = $clog2(MIX_TICKS + 1);
    localparam int SW = VOL_W + 2;

    typedef enum logic [1:0] {IDLE, MIX, DOSED} state_t;

    logic [TW-1:0]    tcnt_q, tcnt_d;
    logic [VOL_W-1:0] vol_q, vol_d;
    logic             ovf_q, ovf_d;
    logic signed [SW-1:0] add, sub, nxt;
    logic             tick, over, mix_ok;
    state_t           state_q;
    logic [MW-1:0]    mix_q;

    always_comb begin
        tick   = tcnt_q == TW'(TICK_DIV - 1);
        tcnt_d = tick ? '0 : tcnt_q + 1'b1;
        add    = Ve ? SW'(FILL_STEP) : '0;
        sub    = Limp ? SW'(CLEAN_STEP) : (Asp ? SW'(DRAIN_STEP) : '0);
        nxt    = $signed({2'b00, vol_q}) + add - sub;
        over   = nxt > SW'(CAP);
        vol_d  = !tick ? vol_q : nxt[SW-1] ? '0 : over ? VOL_W'(CAP) : nxt[VOL_W-1:0];
        ovf_d  = tick && Ve && over;
        mix_ok = Mist && !Limp && vol_q >= VOL_W'(TH0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcnt_q <= '0;
            vol_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            vol_q  <= vol_d;
            ovf_q  <= ovf_d;
        end
    end

    // DOSED leaves on any clock once the tank is empty, not only on ticks
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            mix_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (tick && mix_ok) begin
                    mix_q   <= MW'(1);
                    state_q <= (MIX_TICKS == 1) ? DOSED : MIX;
                end
                MIX: if (tick) begin
                    if (!mix_ok) begin
                        mix_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        mix_q <= mix_q + 1'b1;
                        if (mix_q + 1'b1 == MW'(MIX_TICKS)) state_q <= DOSED;
                    end
                end
                DOSED: if (vol_q == '0) begin
                    mix_q   <= '0;
                    state_q <= IDLE;
                end
                default: begin
                    mix_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign Nv0  = vol_q >= VOL_W'(TH0);
    assign Nv1  = vol_q >= VOL_W'(TH1);
    assign Nv2  = vol_q >= VOL_W'(TH2);
    assign Adub = state_q == DOSED;
    assign Ovf  = ovf_q;
endmodule

// File: tb/tb_tanque_sensor_nivel.sv
// tb_tanque_sensor_nivel: directed checks of the tank plant model (default and TICK_DIV=1/MIX_TICKS=1)
module tb_tanque_sensor_nivel;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1, Ve = 1'b0, Mist = 1'b0, Limp = 1'b0, Asp = 1'b0;
    logic Nv0, Nv1, Nv2, Adub, Ovf;
    logic r1 = 1'b1, ve1 = 1'b0, mist1 = 1'b0, limp1 = 1'b0, asp1 = 1'b0;
    logic n0_1, n1_1, n2_1, adub1, ovf1;
    int pass_n = 0, total_n = 0, ovf_cnt = 0;

    tanque_sensor_nivel dut (
        .clk(clk), .reset(reset), .Ve(Ve), .Mist(Mist), .Limp(Limp), .Asp(Asp),
        .Nv0(Nv0), .Nv1(Nv1), .Nv2(Nv2), .Adub(Adub), .Ovf(Ovf)
    );

    tanque_sensor_nivel #(.TICK_DIV(1), .MIX_TICKS(1)) dut1 (
        .clk(clk), .reset(r1), .Ve(ve1), .Mist(mist1), .Limp(limp1), .Asp(asp1),
        .Nv0(n0_1), .Nv1(n1_1), .Nv2(n2_1), .Adub(adub1), .Ovf(ovf1)
    );

    always @(negedge clk) if (Ovf) ovf_cnt++;

    task automatic do_reset();
        {Ve, Mist, Limp, Asp} = 4'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (4 * n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        total_n++; if ({Nv2, Nv1, Nv0, Adub, Ovf} !== 5'b0) $display("FAIL reset_outs got %b want 00000", {Nv2, Nv1, Nv0, Adub, Ovf}); else pass_n++;
        Ve = 1'b1;
        step(6);
        total_n++; if (dut.vol_q !== 8'd24 || Nv0 !== 1'b1) $display("FAIL pre_reset_vol got %0d/%b want 24/1", dut.vol_q, Nv0); else pass_n++;
        #2 reset = 1'b1;
        #1;
        total_n++; if ({Nv2, Nv1, Nv0, Adub, Ovf} !== 5'b0 || dut.vol_q !== 8'd0) $display("FAIL async_reset got %b vol %0d want 00000 vol 0", {Nv2, Nv1, Nv0, Adub, Ovf}, dut.vol_q); else pass_n++;
        @(negedge clk) reset = 1'b0;
        Ve = 1'b0;
    endtask

    task automatic test_fill();
        do_reset();
        ovf_cnt = 0;
        Ve = 1'b1;
        step(4);
        total_n++; if (dut.vol_q !== 8'd16 || Nv0 !== 1'b0) $display("FAIL fill_t4 got %0d/%b want 16/0", dut.vol_q, Nv0); else pass_n++;
        step(1);
        total_n++; if (dut.vol_q !== 8'd20 || Nv0 !== 1'b1) $display("FAIL fill_t5 got %0d/%b want 20/1", dut.vol_q, Nv0); else pass_n++;
        step(19);
        total_n++; if (Nv1 !== 1'b0) $display("FAIL fill_t24_nv1 got %b want 0", Nv1); else pass_n++;
        step(1);
        total_n++; if (dut.vol_q !== 8'd100 || Nv1 !== 1'b1) $display("FAIL fill_t25 got %0d/%b want 100/1", dut.vol_q, Nv1); else pass_n++;
        step(19);
        total_n++; if (Nv2 !== 1'b0) $display("FAIL fill_t44_nv2 got %b want 0", Nv2); else pass_n++;
        step(1);
        total_n++; if (dut.vol_q !== 8'd180 || Nv2 !== 1'b1) $display("FAIL fill_t45 got %0d/%b want 180/1", dut.vol_q, Nv2); else pass_n++;
        step(5);
        total_n++; if (dut.vol_q !== 8'd200 || ovf_cnt !== 0) $display("FAIL fill_t50 got vol %0d ovf_cnt %0d want 200/0", dut.vol_q, ovf_cnt); else pass_n++;
        repeat (3) @(posedge clk);
        #1;
        total_n++; if (Ovf !== 1'b0) $display("FAIL ovf_early got %b want 0", Ovf); else pass_n++;
        @(posedge clk) #1;
        total_n++; if (Ovf !== 1'b1 || dut.vol_q !== 8'd200) $display("FAIL ovf_t51 got %b vol %0d want 1 vol 200", Ovf, dut.vol_q); else pass_n++;
        @(posedge clk) #1;
        total_n++; if (Ovf !== 1'b0 || ovf_cnt !== 1) $display("FAIL ovf_pulse got %b cnt %0d want 0 cnt 1", Ovf, ovf_cnt); else pass_n++;
        Ve = 1'b0;
    endtask

    task automatic test_mix_and_clean();
        do_reset();
        Ve = 1'b1;
        step(25);
        Ve = 1'b0; Mist = 1'b1;
        step(4);
        total_n++; if (Adub !== 1'b0) $display("FAIL mix_t4 got %b want 0", Adub); else pass_n++;
        step(1);
        total_n++; if (Adub !== 1'b1 || dut.vol_q !== 8'd100) $display("FAIL mix_t5 got %b vol %0d want 1 vol 100", Adub, dut.vol_q); else pass_n++;
        Mist = 1'b0; Limp = 1'b1; Asp = 1'b1;
        step(1);
        total_n++; if (dut.vol_q !== 8'd92 || Nv1 !== 1'b0 || Adub !== 1'b1) $display("FAIL clean_t1 got %0d/%b/%b want 92/0/1", dut.vol_q, Nv1, Adub); else pass_n++;
        step(9);
        total_n++; if (dut.vol_q !== 8'd20 || Nv0 !== 1'b1) $display("FAIL clean_t10 got %0d/%b want 20/1", dut.vol_q, Nv0); else pass_n++;
        step(1);
        total_n++; if (dut.vol_q !== 8'd12 || Nv0 !== 1'b0) $display("FAIL clean_t11 got %0d/%b want 12/0", dut.vol_q, Nv0); else pass_n++;
        step(1);
        total_n++; if (dut.vol_q !== 8'd4) $display("FAIL clean_t12 got %0d want 4", dut.vol_q); else pass_n++;
        step(1);
        total_n++; if (dut.vol_q !== 8'd0 || Adub !== 1'b1 || {Nv2, Nv1, Nv0} !== 3'b000) $display("FAIL clean_t13 got vol %0d adub %b nv %b want 0/1/000", dut.vol_q, Adub, {Nv2, Nv1, Nv0}); else pass_n++;
        @(posedge clk) #1;
        total_n++; if (Adub !== 1'b0 || dut.vol_q !== 8'd0) $display("FAIL adub_fall got %b vol %0d want 0 vol 0", Adub, dut.vol_q); else pass_n++;
        {Limp, Asp} = 2'b0;
    endtask

    task automatic test_mist_drop();
        do_reset();
        Ve = 1'b1;
        step(25);
        Ve = 1'b0; Mist = 1'b1;
        step(2);
        Mist = 1'b0;
        step(1);
        total_n++; if (Adub !== 1'b0 || dut.mix_q !== 0) $display("FAIL drop_abort got %b cnt %0d want 0 cnt 0", Adub, dut.mix_q); else pass_n++;
        Mist = 1'b1;
        step(4);
        total_n++; if (Adub !== 1'b0) $display("FAIL drop_restart4 got %b want 0", Adub); else pass_n++;
        step(1);
        total_n++; if (Adub !== 1'b1) $display("FAIL drop_restart5 got %b want 1", Adub); else pass_n++;
        Mist = 1'b0;
    endtask

    task automatic test_low_vol();
        do_reset();
        Ve = 1'b1;
        step(4);
        Ve = 1'b0; Mist = 1'b1;
        step(10);
        total_n++; if (Adub !== 1'b0 || Nv0 !== 1'b0 || dut.vol_q !== 8'd16) $display("FAIL low_vol got %b/%b/%0d want 0/0/16", Adub, Nv0, dut.vol_q); else pass_n++;
        Mist = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        Ve = 1'b1;
        step(12);
        Asp = 1'b1;
        step(1);
        total_n++; if (dut.vol_q !== 8'd50) $display("FAIL ve_asp_50 got %0d want 50", dut.vol_q); else pass_n++;
        step(1);
        total_n++; if (dut.vol_q !== 8'd52) $display("FAIL ve_asp_52 got %0d want 52", dut.vol_q); else pass_n++;
        step(2);
        total_n++; if (dut.vol_q !== 8'd56 || {Nv2, Nv1, Nv0} !== 3'b001) $display("FAIL ve_asp_56 got %0d nv %b want 56 nv 001", dut.vol_q, {Nv2, Nv1, Nv0}); else pass_n++;
        Limp = 1'b1;
        step(1);
        total_n++; if (dut.vol_q !== 8'd52) $display("FAIL ve_limp_52 got %0d want 52", dut.vol_q); else pass_n++;
        step(1);
        total_n++; if (dut.vol_q !== 8'd48 || Ovf !== 1'b0) $display("FAIL ve_limp_48 got %0d/%b want 48/0", dut.vol_q, Ovf); else pass_n++;
        {Ve, Limp, Asp} = 3'b0;
    endtask

    task automatic test_reset_mid_mix();
        do_reset();
        Ve = 1'b1;
        step(30);
        Ve = 1'b0; Mist = 1'b1;
        step(3);
        total_n++; if (dut.mix_q !== 3 || dut.vol_q !== 8'd120 || Nv1 !== 1'b1) $display("FAIL mid_mix got cnt %0d vol %0d want 3/120", dut.mix_q, dut.vol_q); else pass_n++;
        #2 reset = 1'b1;
        #1;
        total_n++; if ({Nv2, Nv1, Nv0, Adub, Ovf} !== 5'b0 || dut.mix_q !== 0) $display("FAIL mid_mix_reset got %b cnt %0d want 00000 cnt 0", {Nv2, Nv1, Nv0, Adub, Ovf}, dut.mix_q); else pass_n++;
        @(negedge clk) reset = 1'b0;
        Ve = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total_n++; if (dut.vol_q !== 8'd0) $display("FAIL tick_early got %0d want 0", dut.vol_q); else pass_n++;
        @(posedge clk) #1;
        total_n++; if (dut.vol_q !== 8'd4) $display("FAIL first_tick got %0d want 4", dut.vol_q); else pass_n++;
        step(4);
        Ve = 1'b0;
        step(4);
        total_n++; if (Adub !== 1'b0 || dut.vol_q !== 8'd20) $display("FAIL remix4 got %b vol %0d want 0 vol 20", Adub, dut.vol_q); else pass_n++;
        step(1);
        total_n++; if (Adub !== 1'b1) $display("FAIL remix5 got %b want 1", Adub); else pass_n++;
        Mist = 1'b0;
    endtask

    task automatic test_sweep();
        r1 = 1'b1;
        @(posedge clk);
        @(negedge clk) r1 = 1'b0;
        ve1 = 1'b1;
        @(posedge clk) #1;
        total_n++; if (dut1.vol_q !== 8'd4) $display("FAIL sweep_clk1 got %0d want 4", dut1.vol_q); else pass_n++;
        repeat (4) @(posedge clk);
        #1;
        total_n++; if (dut1.vol_q !== 8'd20 || n0_1 !== 1'b1 || adub1 !== 1'b0) $display("FAIL sweep_clk5 got %0d/%b/%b want 20/1/0", dut1.vol_q, n0_1, adub1); else pass_n++;
        ve1 = 1'b0; mist1 = 1'b1;
        @(posedge clk) #1;
        total_n++; if (adub1 !== 1'b1) $display("FAIL sweep_dosed got %b want 1", adub1); else pass_n++;
        mist1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_mix_and_clean();
        test_mist_drop();
        test_low_vol();
        test_back_to_back();
        test_reset_mid_mix();
        test_sweep();
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
